// File: rtl/slave_bridge_tg_sched.sv
// Traffic-generator run scheduler: paces write/read issue pulses against monitored AXI handshakes.
// Optional response checking (err_cnt) is enabled by defining TG_SCHED_RESP_CHECK_EN.
module slave_bridge_tg_sched #(
  parameter int          TCQ             = 1,
  parameter int unsigned MAX_OUTSTANDING = 16,
  parameter int unsigned CNT_WIDTH       = 16
) (
  input  logic                 fabric_clk,
  input  logic                 fabric_rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 cfg_mode,
  input  logic [CNT_WIDTH-1:0] cfg_num_wr,
  input  logic [CNT_WIDTH-1:0] cfg_num_rd,
  input  logic                 awvalid,
  input  logic                 awready,
  input  logic                 bvalid,
  input  logic                 bready,
  input  logic                 arvalid,
  input  logic                 arready,
  input  logic                 rvalid,
  input  logic                 rready,
  input  logic                 rlast,
  input  logic [1:0]           bresp,
  input  logic [1:0]           rresp,
  output logic                 gen_wr,
  output logic                 gen_rd,
  output logic                 busy,
  output logic                 done,
  output logic                 aborted,
  output logic [CNT_WIDTH-1:0] wr_cmpl_cnt,
  output logic [CNT_WIDTH-1:0] rd_cmpl_cnt,
  output logic [CNT_WIDTH-1:0] err_cnt
);

  localparam int unsigned OutW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [OutW-1:0] MaxOut = OutW'(MAX_OUTSTANDING);
  localparam logic [OutW-1:0] OutOne = OutW'(1);
  localparam logic [CNT_WIDTH-1:0] CntOne = CNT_WIDTH'(1);
  // Registers model zero clock-to-Q; TCQ is kept only so existing instantiations still bind.
  localparam int unused_tcq = TCQ;

  typedef enum logic [2:0] {StIdle, StWrPh, StRdPh, StConc, StDrain, StDone} state_e;

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] num_wr_q, num_rd_q, wr_issued_q, rd_issued_q;
  logic [CNT_WIDTH-1:0] wr_cmpl_q, rd_cmpl_q;
  logic [OutW-1:0]      wr_out_q, rd_out_q;
  logic                 wr_pend_q, rd_pend_q, via_drain_q;
  logic                 active, launch, aw_hs, b_hs, ar_hs, r_hs;
  logic                 wr_finished, rd_finished;

  assign active = (state_q != StIdle);
  assign launch = (state_q == StIdle) && start;
  assign aw_hs  = active && awvalid && awready;
  assign b_hs   = active && bvalid && bready;
  assign ar_hs  = active && arvalid && arready;
  assign r_hs   = active && rvalid && rready && rlast;

  // Pending request counts as in flight so a phase cannot close before its last AW/AR lands.
  assign wr_finished = (wr_issued_q == num_wr_q) && !wr_pend_q && (wr_out_q == '0);
  assign rd_finished = (rd_issued_q == num_rd_q) && !rd_pend_q && (rd_out_q == '0);

  assign gen_wr = ((state_q == StWrPh) || (state_q == StConc)) && !abort &&
                  (wr_issued_q < num_wr_q) && !wr_pend_q && (wr_out_q < MaxOut);
  assign gen_rd = ((state_q == StRdPh) || (state_q == StConc)) && !abort &&
                  (rd_issued_q < num_rd_q) && !rd_pend_q && (rd_out_q < MaxOut);

  assign busy        = active;
  assign done        = (state_q == StDone);
  assign aborted     = done && via_drain_q;
  assign wr_cmpl_cnt = wr_cmpl_q;
  assign rd_cmpl_cnt = rd_cmpl_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = cfg_mode ? StConc : StWrPh;
      StWrPh:  if (abort) state_d = StDrain; else if (wr_finished) state_d = StRdPh;
      StRdPh:  if (abort) state_d = StDrain; else if (rd_finished) state_d = StDone;
      StConc:  if (abort) state_d = StDrain;
               else if (wr_finished && rd_finished) state_d = StDone;
      StDrain: if ((wr_out_q == '0) && (rd_out_q == '0)) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge fabric_clk or posedge fabric_rst) begin
    if (fabric_rst) begin
      state_q     <= StIdle;
      num_wr_q    <= '0;
      num_rd_q    <= '0;
      wr_issued_q <= '0;
      rd_issued_q <= '0;
      wr_pend_q   <= 1'b0;
      rd_pend_q   <= 1'b0;
      wr_out_q    <= '0;
      rd_out_q    <= '0;
      wr_cmpl_q   <= '0;
      rd_cmpl_q   <= '0;
      via_drain_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (launch) begin
        num_wr_q    <= cfg_num_wr;
        num_rd_q    <= cfg_num_rd;
        wr_issued_q <= '0;
        rd_issued_q <= '0;
        wr_pend_q   <= 1'b0;
        rd_pend_q   <= 1'b0;
        wr_out_q    <= '0;
        rd_out_q    <= '0;
        wr_cmpl_q   <= '0;
        rd_cmpl_q   <= '0;
        via_drain_q <= 1'b0;
      end else begin
        if (gen_wr) wr_issued_q <= wr_issued_q + CntOne;
        if (gen_rd) rd_issued_q <= rd_issued_q + CntOne;
        if (gen_wr) wr_pend_q <= 1'b1;
        else if (aw_hs) wr_pend_q <= 1'b0;
        if (gen_rd) rd_pend_q <= 1'b1;
        else if (ar_hs) rd_pend_q <= 1'b0;
        if (aw_hs && !b_hs) wr_out_q <= wr_out_q + OutOne;
        else if (b_hs && !aw_hs && (wr_out_q != '0)) wr_out_q <= wr_out_q - OutOne;
        if (ar_hs && !r_hs) rd_out_q <= rd_out_q + OutOne;
        else if (r_hs && !ar_hs && (rd_out_q != '0)) rd_out_q <= rd_out_q - OutOne;
        if (b_hs && !(&wr_cmpl_q)) wr_cmpl_q <= wr_cmpl_q + CntOne;
        if (r_hs && !(&rd_cmpl_q)) rd_cmpl_q <= rd_cmpl_q + CntOne;
        if (state_d == StDrain) via_drain_q <= 1'b1;
      end
    end
  end

`ifdef TG_SCHED_RESP_CHECK_EN
  logic [CNT_WIDTH-1:0] err_q;
  logic [1:0]           err_inc;
  logic [CNT_WIDTH:0]   err_sum;
  logic                 r_beat;

  // Every R beat carries a response, not just the last one.
  assign r_beat  = active && rvalid && rready;
  assign err_inc = 2'(b_hs && (bresp != 2'b00)) + 2'(r_beat && (rresp != 2'b00));
  assign err_sum = {1'b0, err_q} + (CNT_WIDTH + 1)'(err_inc);

  always_ff @(posedge fabric_clk or posedge fabric_rst) begin
    if (fabric_rst) begin
      err_q <= '0;
    end else if (launch) begin
      err_q <= '0;
    end else if (err_sum[CNT_WIDTH]) begin
      err_q <= '1;
    end else begin
      err_q <= err_sum[CNT_WIDTH-1:0];
    end
  end

  assign err_cnt = err_q;
`else
  logic unused_resp;
  assign unused_resp = ^{bresp, rresp};
  assign err_cnt     = '0;
`endif

endmodule
